snes_pad_reader: RTL and testbench

Host-side poller for a physical SNES/NES gamepad wired to ULX3S GPIO. It drives the pad's latch and clock lines and shifts in the 16-bit serial button word. It publishes the result as an active-low button vector in the same bit order the top level feeds into the SNES core's JOY1 shift register. This is the initiator end of the joypad serial protocol whose responder end lives in the top level.

---
 rtl/snes_pad_pkg.sv | 33 +++
 rtl/snes_pad_sync.sv | 22 ++
 rtl/snes_pad_reader.sv | 193 +++++++++++++++++++
 tb/tb_snes_pad_reader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/snes_pad_pkg.sv
// Shared types and constants for the SNES/NES gamepad poller.
// Used by snes_pad_reader and snes_pad_sync.
package snes_pad_pkg;

    localparam int unsigned PAD_BITS  = 16;
    localparam int unsigned PAD_IDX_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LGAP,
        CLK_LO,
        CLK_HI,
        DONE
    } pad_state_t;

    // Bit positions in the active-low button word, matching the JOY1 shift order
    localparam int unsigned PAD_B      = 0;
    localparam int unsigned PAD_Y      = 1;
    localparam int unsigned PAD_SELECT = 2;
    localparam int unsigned PAD_START  = 3;
    localparam int unsigned PAD_UP     = 4;
    localparam int unsigned PAD_DOWN   = 5;
    localparam int unsigned PAD_LEFT   = 6;
    localparam int unsigned PAD_RIGHT  = 7;
    localparam int unsigned PAD_A      = 8;
    localparam int unsigned PAD_X      = 9;
    localparam int unsigned PAD_L      = 10;
    localparam int unsigned PAD_R      = 11;

    localparam logic [PAD_BITS-1:0] PAD_IDLE_WORD = 16'hFFFF;

endpackage

// File: rtl/snes_pad_sync.sv
// Two-flop synchroniser for the asynchronous pad data line.
// Resets to 1 so an idle (pulled-up) line reads as "released".
module snes_pad_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/snes_pad_reader.sv
// Host-side SNES/NES gamepad poller: drives latch/clock, shifts in 16 bits.
// Optional SNES_PAD_DEBOUNCE_EN: publish only when two consecutive polls agree.
module snes_pad_reader
    import snes_pad_pkg::*;
#(
    parameter int unsigned C_HALF_DIV = 128,
    parameter int unsigned C_POLL_DIV = 357954
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                poll_req,
    input  logic                pad_data,
    output logic                pad_latch,
    output logic                pad_clk,
    output logic [PAD_BITS-1:0] buttons_n,
    output logic                valid,
    output logic                busy
);

    localparam int unsigned CNT_W = $clog2(2 * C_HALF_DIV);
    localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(2 * C_HALF_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(C_HALF_DIV - 1);
    localparam logic [PAD_IDX_W-1:0] LAST_IDX = PAD_IDX_W'(PAD_BITS - 1);

    pad_state_t            state, state_nxt;
    logic [CNT_W-1:0]      phase_cnt, phase_nxt;
    logic [PAD_IDX_W-1:0]  bit_idx, bit_idx_nxt;
    logic [PAD_BITS-1:0]   shift, shift_nxt;
    logic                  pending, pending_nxt;
    logic                  pad_data_s;
    logic                  poll_tick;
    logic                  start;
    logic                  phase_done;
    logic                  enter_done;
    logic                  accept;

    snes_pad_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pad_data),
        .q     (pad_data_s)
    );

    // Free-running auto-poll timer; keeps counting while a poll is in flight
    generate
        if (C_POLL_DIV == 0) begin : g_no_timer
            assign poll_tick = 1'b0;
        end else begin : g_timer
            localparam int unsigned TW = (C_POLL_DIV > 1) ? $clog2(C_POLL_DIV) : 1;
            localparam logic [TW-1:0] TIMER_LAST = TW'(C_POLL_DIV - 1);
            logic [TW-1:0] poll_cnt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    poll_cnt <= '0;
                end else if (poll_cnt == TIMER_LAST) begin
                    poll_cnt <= '0;
                end else begin
                    poll_cnt <= poll_cnt + TW'(1);
                end
            end

            assign poll_tick = (poll_cnt == TIMER_LAST);
        end
    endgenerate

    assign start      = poll_req | poll_tick | pending;
    assign phase_done = (phase_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase_cnt <= '0;
            bit_idx   <= '0;
            shift     <= PAD_IDLE_WORD;
            pending   <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_nxt;
            bit_idx   <= bit_idx_nxt;
            shift     <= shift_nxt;
            pending   <= pending_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase_cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        pending_nxt = pending;
        enter_done  = 1'b0;

        if (state != IDLE && (poll_req || poll_tick)) begin
            pending_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = LATCH;
                    phase_nxt   = LATCH_LOAD;
                    pending_nxt = 1'b0;
                end
            end
            LATCH: begin
                if (phase_done) begin
                    state_nxt = LGAP;
                    phase_nxt = HALF_LOAD;
                end else begin
                    phase_nxt = phase_cnt - CNT_W'(1);
                end
            end
            LGAP: begin
                // Latch released: the pad already presents bit 0
                if (phase_done) begin
                    shift_nxt[0] = pad_data_s;
                    bit_idx_nxt  = PAD_IDX_W'(1);
                    state_nxt    = CLK_LO;
                    phase_nxt    = HALF_LOAD;
                end else begin
                    phase_nxt = phase_cnt - CNT_W'(1);
                end
            end
            CLK_LO: begin
                if (phase_done) begin
                    state_nxt = CLK_HI;
                    phase_nxt = HALF_LOAD;
                end else begin
                    phase_nxt = phase_cnt - CNT_W'(1);
                end
            end
            CLK_HI: begin
                // Sample late in the high phase so the synchroniser has settled
                if (phase_done) begin
                    shift_nxt[bit_idx] = pad_data_s;
                    if (bit_idx == LAST_IDX) begin
                        state_nxt  = DONE;
                        enter_done = 1'b1;
                    end else begin
                        bit_idx_nxt = bit_idx + PAD_IDX_W'(1);
                        state_nxt   = CLK_LO;
                        phase_nxt   = HALF_LOAD;
                    end
                end else begin
                    phase_nxt = phase_cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef SNES_PAD_DEBOUNCE_EN
    logic [PAD_BITS-1:0] prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= PAD_IDLE_WORD;
        end else if (enter_done) begin
            prev <= shift_nxt;
        end
    end

    assign accept = enter_done && (shift_nxt == prev);
`else
    assign accept = enter_done;
`endif

    // Outputs are registered from the next state so they align with the state they belong to
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pad_latch <= 1'b0;
            pad_clk   <= 1'b1;
            buttons_n <= PAD_IDLE_WORD;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            pad_latch <= (state_nxt == LATCH);
            pad_clk   <= (state_nxt != CLK_LO);
            busy      <= (state_nxt != IDLE);
            valid     <= accept;
            if (accept) begin
                buttons_n <= shift_nxt;
            end
        end
    end

endmodule

// File: tb/tb_snes_pad_reader.sv
// Scoreboard bench for snes_pad_reader with a behavioural pad model.
// Also consistent with builds that define SNES_PAD_DEBOUNCE_EN.
module tb_snes_pad_reader;

    localparam int unsigned D = 4;
    localparam int unsigned P = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        poll_req;
    logic        pad_data;
    logic        pad_latch;
    logic        pad_clk;
    logic [15:0] buttons_n;
    logic        valid;
    logic        busy;

    always #5 clk = ~clk;

    snes_pad_reader #(.C_HALF_DIV(D), .C_POLL_DIV(P)) dut (
        .clk       (clk),
        .reset     (reset),
        .poll_req  (poll_req),
        .pad_data  (pad_data),
        .pad_latch (pad_latch),
        .pad_clk   (pad_clk),
        .buttons_n (buttons_n),
        .valid     (valid),
        .busy      (busy)
    );

    // Pad model: latch reloads, each rising pad_clk advances to the next bit
    logic [15:0] word = 16'hFFFF;
    logic [4:0]  pad_idx = 5'd0;

    always @(posedge pad_latch) pad_idx = 5'd0;
    always @(posedge pad_clk) if (!pad_latch && pad_idx != 5'd16) pad_idx = pad_idx + 5'd1;
    assign pad_data = pad_idx[4] ? 1'b1 : word[pad_idx[3:0]];

    // cyc equals the DUT timer value while both count from reset release
    int cyc;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        logic [15:0] w;
        int          at;
    } exp_t;

    exp_t        q[$];
    logic [15:0] prev_word = 16'hFFFF;
    int          checks = 0;
    int          errors = 0;

    task automatic expect_poll(input logic [15:0] w, input int at);
`ifdef SNES_PAD_DEBOUNCE_EN
        if (w == prev_word) q.push_back('{w, at});
        prev_word = w;
`else
        q.push_back('{w, at});
`endif
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h want %0h", name, cyc, got, want);
        end
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic pulse(input int k);
        wait_cyc(k);
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
    endtask

    // Monitor: every valid pulse must match the head of the expectation queue
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (q.size() > 0 && q[0].at < cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_valid: no pulse for word %h expected at cyc %0d", e.w, e.at);
            end
            if (valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid at cyc %0d: got word %h want no pulse", cyc, buttons_n);
                end else begin
                    e = q.pop_front();
                    if (e.w !== buttons_n || e.at != cyc) begin
                        errors++;
                        $display("FAIL poll_word: got %h at cyc %0d want %h at cyc %0d",
                                 buttons_n, cyc, e.w, e.at);
                    end
                end
            end
        end
    end

    initial begin
        int lows;
        int falls;
        logic prev_pc;

        reset    = 1'b1;
        poll_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_latch", 32'(pad_latch), 32'd0);
        chk("rst_clk",   32'(pad_clk),   32'd1);
        chk("rst_btn",   32'(buttons_n), 32'hFFFF);
        chk("rst_valid", 32'(valid),     32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        reset = 1'b0;

        // Single poll with a full waveform trace
        word = 16'hFEFE;
        expect_poll(16'hFEFE, 5 + 33 * D + 1);
        lows    = 0;
        falls   = 0;
        prev_pc = 1'b1;
        wait_cyc(5);
        poll_req = 1'b1;
        for (int c = 5; c <= 5 + 33 * int'(D) + 2; c++) begin
            chk("latch_trace", 32'(pad_latch), 32'(cyc >= 6 && cyc <= 5 + 2 * int'(D)));
            chk("busy_trace",  32'(busy),      32'(cyc >= 6 && cyc <= 5 + 33 * int'(D) + 1));
            if (!pad_clk) lows++;
            if (prev_pc && !pad_clk) falls++;
            prev_pc = pad_clk;
            @(negedge clk);
            poll_req = 1'b0;
        end
        chk("clk_low_cycles", 32'(lows),  32'd60);
        chk("clk_low_pulses", 32'(falls), 32'd15);

        // Three requests during one poll collapse into one follow-up
        word = 16'h7BDE;
        expect_poll(16'h7BDE, 333);
        expect_poll(16'h5A3C, 467);
        pulse(200);
        pulse(210);
        pulse(220);
        pulse(230);
        wait_cyc(333);
        word = 16'h5A3C;
        chk("busy_done", 32'(busy), 32'd1);
        wait_cyc(334);
        chk("busy_gap", 32'(busy), 32'd0);
        wait_cyc(335);
        chk("busy_followup", 32'(busy), 32'd1);
        wait_cyc(469);
        chk("no_third_poll", 32'(busy), 32'd0);

        // Auto-poll with released pad; request coinciding with a tick
        wait_cyc(500);
        word = 16'hFFFF;
        expect_poll(16'hFFFF, 1132);
        expect_poll(16'hFFFF, 2132);
        pulse(1999);
        wait_cyc(2134);
        chk("coincide_single", 32'(busy), 32'd0);
        word = 16'h0F0F;
        expect_poll(16'h0F0F, 3132);

        // Reset 50 cycles into a poll
        pulse(3500);
        wait_cyc(3550);
        reset = 1'b1;
        #1;
        chk("mid_rst_latch", 32'(pad_latch), 32'd0);
        chk("mid_rst_clk",   32'(pad_clk),   32'd1);
        chk("mid_rst_btn",   32'(buttons_n), 32'hFFFF);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        chk("mid_rst_valid", 32'(valid),     32'd0);
        repeat (3) @(negedge clk);
        reset     = 1'b0;
        prev_word = 16'hFFFF;

        // Resumed polling, repeated word, and timer restarted from zero
        word = 16'hFFFE;
        expect_poll(16'hFFFE, 143);
        pulse(10);
        expect_poll(16'hFFFE, 333);
        pulse(200);
        wait_cyc(340);
        word = 16'h1234;
        expect_poll(16'h1234, 533);
        pulse(400);
        expect_poll(16'h1234, 1132);
        wait_cyc(1200);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
